// File: rtl/eig_stream_engine.sv
// eig_stream_engine: byte-loaded 2x2 eigen-analysis engine.
// Coefficients a0/a1 of p(x)=x^2+a1*x+a0 (signed Q16.16) are loaded byte-wise,
// a sequential core classifies the root regime and computes kappa=|lmax|/|lmin|
// (and optionally 1/kappa), and the result is streamed out one byte per cycle.
// Optional feature macro: EIG_INV_KAPPA_EN adds the 1/kappa divide pass and the
// four trailing inverse bytes of the stream; without it inv is forced to 0.
module eig_stream_engine (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    localparam int          DATA_W    = 32;
    localparam logic [5:0]  SQRT_LAST = 6'd32;   // 33 root bits
    localparam logic [5:0]  DIV_LAST  = 6'd47;   // 48 quotient bits
`ifdef EIG_INV_KAPPA_EN
    localparam logic [5:0]  STREAM_LAST = 6'd8;  // header + kappa + inv
`else
    localparam logic [5:0]  STREAM_LAST = 6'd4;  // header + kappa
`endif
    localparam logic [31:0] KAPPA_SAT = 32'h7FFF_FFFF;
    localparam logic [31:0] ONE_Q16   = 32'h0001_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISC,
        S_SQRT,
        S_DIVK,
        S_DIVI,
        S_DONE,
        S_STREAM
    } state_t;

    state_t state_q, state_d;

    // Control registers (reset)
    logic [5:0]               cnt_q;
    logic                     go_prev_q, ld_prev_q;
    logic signed [DATA_W-1:0] a0_q, a1_q;
    logic [2:0]               regime_q;
    logic [31:0]              kappa_q, inv_q;

    // Datapath registers (no reset; always written before use)
    logic signed [DATA_W-1:0] a0_s, a1_s;
    logic                     d_neg, d_zero;
    logic [65:0]              sq_rad;
    logic [34:0]              sq_rem;
    logic [32:0]              sq_root;
    logic [47:0]              dv_num;     // dividend shifts out, quotient shifts in
    logic [31:0]              dv_den;
    logic [31:0]              dv_rem;
    logic [31:0]              kappa_raw;
`ifdef EIG_INV_KAPPA_EN
    logic [31:0]              sum_hold, diff_hold;
    logic [31:0]              inv_raw;
`endif

    logic go_edge, ld_edge;
    logic unused_ui_bits;

    assign go_edge        = ena & ui_in[6] & ~go_prev_q;
    assign ld_edge        = ena & ui_in[7] & ~ld_prev_q;
    assign unused_ui_bits = ^ui_in[5:3];
    assign uio_out        = 8'h00;
    assign uio_oe         = 8'h00;

    // Clamp a 48-bit quotient into the 31-bit positive range; zero divisor saturates.
    function automatic logic [31:0] sat_quot(input logic [47:0] q, input logic den_zero);
        if (den_zero || (q[47:31] != '0)) return KAPPA_SAT;
        return q[31:0];
    endfunction

    // ---- Stage: discriminant D = a1^2 - 4*a0 in Q32.32 ----
    logic signed [67:0] a1_x, a0_x, disc;
    logic [65:0]        disc_mag;
    logic [31:0]        abs_a1;

    // Sign-extend the snapshot operands and form |D| and |a1|.
    always_comb begin
        a1_x     = {{36{a1_s[31]}}, a1_s};
        a0_x     = {{36{a0_s[31]}}, a0_s};
        disc     = (a1_x * a1_x) - (a0_x <<< 18);
        disc_mag = disc[67] ? 66'(-disc) : 66'(disc);
        abs_a1   = a1_s[31] ? 32'(-a1_s) : 32'(a1_s);
    end

    // ---- Stage: restoring square root, one result bit per cycle ----
    logic [36:0] sq_rem_sh, sq_trial;
    logic        sq_ge;
    logic [34:0] sq_rem_nxt;
    logic [32:0] sq_root_nxt;

    // One restoring-sqrt iteration: bring down two radicand bits and trial-subtract.
    always_comb begin
        sq_rem_sh   = {sq_rem, sq_rad[65:64]};
        sq_trial    = {2'b00, sq_root, 2'b01};
        sq_ge       = (sq_rem_sh >= sq_trial);
        sq_rem_nxt  = sq_ge ? 35'(sq_rem_sh - sq_trial) : sq_rem_sh[34:0];
        sq_root_nxt = {sq_root[31:0], sq_ge};
    end

    // ---- Stage: divider operands |a1|+s and ||a1|-s| ----
    logic [33:0] op_sum, op_diff;
    logic [31:0] op_sum32, op_diff32;

    // Build the ratio operands from the final root; rescale both when the sum overflows 32 bits.
    always_comb begin
        op_sum  = {2'b00, abs_a1} + {1'b0, sq_root_nxt};
        op_diff = ({1'b0, sq_root_nxt} > {2'b00, abs_a1})
                ? ({1'b0, sq_root_nxt} - {2'b00, abs_a1})
                : ({2'b00, abs_a1} - {1'b0, sq_root_nxt});
        if (op_sum[33:32] != 2'b00) begin
            op_sum32  = op_sum[33:2];
            op_diff32 = op_diff[33:2];
        end else begin
            op_sum32  = op_sum[31:0];
            op_diff32 = op_diff[31:0];
        end
    end

    // ---- Stage: restoring divider, one quotient bit per cycle ----
    logic [32:0] dv_rem_sh;
    logic        dv_ge;
    logic [31:0] dv_rem_nxt;
    logic [47:0] dv_num_nxt;

    // One restoring-division iteration; the quotient bit replaces the consumed dividend bit.
    always_comb begin
        dv_rem_sh  = {dv_rem, dv_num[47]};
        dv_ge      = (dv_rem_sh >= {1'b0, dv_den});
        dv_rem_nxt = dv_ge ? 32'(dv_rem_sh - {1'b0, dv_den}) : dv_rem_sh[31:0];
        dv_num_nxt = {dv_num[46:0], dv_ge};
    end

    // ---- Stage: regime classification and result override ----
    logic [2:0]  res_regime;
    logic [31:0] res_kappa, res_inv;

    // Priority: singular, repeated, complex, then the computed real-distinct values.
    always_comb begin
        res_regime = 3'd1;
        res_kappa  = kappa_raw;
`ifdef EIG_INV_KAPPA_EN
        res_inv    = inv_raw;
`else
        res_inv    = '0;
`endif
        if (a0_s == '0) begin
            res_regime = 3'd4;
            res_kappa  = KAPPA_SAT;
            res_inv    = '0;
        end else if (d_zero) begin
            res_regime = 3'd2;
            res_kappa  = ONE_Q16;
            res_inv    = ONE_Q16;
        end else if (d_neg) begin
            res_regime = 3'd3;
            res_kappa  = ONE_Q16;
            res_inv    = ONE_Q16;
        end
`ifndef EIG_INV_KAPPA_EN
        res_inv = '0;
`endif
    end

    // FSM next state: fixed-latency walk through every core stage.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (go_edge) state_d = S_DISC;
            S_DISC:   state_d = S_SQRT;
            S_SQRT:   if (cnt_q == SQRT_LAST) state_d = S_DIVK;
`ifdef EIG_INV_KAPPA_EN
            S_DIVK:   if (cnt_q == DIV_LAST) state_d = S_DIVI;
            S_DIVI:   if (cnt_q == DIV_LAST) state_d = S_DONE;
`else
            S_DIVK:   if (cnt_q == DIV_LAST) state_d = S_DONE;
`endif
            S_DONE:   state_d = S_STREAM;
            S_STREAM: if (cnt_q == STREAM_LAST) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM state register; ena low freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state_q <= S_IDLE;
        else if (ena) state_q <= state_d;
    end

    // Control state: step counter, edge history, operand loads and published results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            go_prev_q <= 1'b0;
            ld_prev_q <= 1'b0;
            a0_q      <= '0;
            a1_q      <= '0;
            regime_q  <= '0;
            kappa_q   <= '0;
            inv_q     <= '0;
        end else if (ena) begin
            cnt_q     <= (state_d != state_q) ? 6'd0 : cnt_q + 6'd1;
            go_prev_q <= ui_in[6];
            ld_prev_q <= ui_in[7];
            if (ld_edge) begin
                if (ui_in[2]) a1_q[{ui_in[1:0], 3'b000} +: 8] <= uio_in;
                else          a0_q[{ui_in[1:0], 3'b000} +: 8] <= uio_in;
            end
            if (state_q == S_DONE) begin
                regime_q <= res_regime;
                kappa_q  <= res_kappa;
                inv_q    <= res_inv;
            end
        end
    end

    // Datapath sequencing: snapshot, sqrt iterations, divider passes.
    always_ff @(posedge clk) begin
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (go_edge) begin
                        a0_s <= a0_q;
                        a1_s <= a1_q;
                    end
                end
                S_DISC: begin
                    sq_rad  <= disc_mag;
                    sq_rem  <= '0;
                    sq_root <= '0;
                    d_neg   <= disc[67];
                    d_zero  <= (disc == '0);
                end
                S_SQRT: begin
                    sq_rad  <= sq_rad << 2;
                    sq_rem  <= sq_rem_nxt;
                    sq_root <= sq_root_nxt;
                    if (cnt_q == SQRT_LAST) begin
                        dv_num <= {op_sum32, 16'h0000};
                        dv_den <= op_diff32;
                        dv_rem <= '0;
`ifdef EIG_INV_KAPPA_EN
                        sum_hold  <= op_sum32;
                        diff_hold <= op_diff32;
`endif
                    end
                end
                S_DIVK: begin
                    dv_num <= dv_num_nxt;
                    dv_rem <= dv_rem_nxt;
                    if (cnt_q == DIV_LAST) begin
                        kappa_raw <= sat_quot(dv_num_nxt, dv_den == '0);
`ifdef EIG_INV_KAPPA_EN
                        dv_num <= {diff_hold, 16'h0000};
                        dv_den <= sum_hold;
                        dv_rem <= '0;
`endif
                    end
                end
`ifdef EIG_INV_KAPPA_EN
                S_DIVI: begin
                    dv_num <= dv_num_nxt;
                    dv_rem <= dv_rem_nxt;
                    if (cnt_q == DIV_LAST) inv_raw <= sat_quot(dv_num_nxt, dv_den == '0);
                end
`endif
                default: ;
            endcase
        end
    end

    // Result stream: header, kappa MSB first, inv MSB first; zero otherwise.
    always_comb begin
        uo_out = 8'h00;
        if (state_q == S_STREAM) begin
            case (cnt_q)
                6'd0:    uo_out = {5'b10100, regime_q};
                6'd1:    uo_out = kappa_q[31:24];
                6'd2:    uo_out = kappa_q[23:16];
                6'd3:    uo_out = kappa_q[15:8];
                6'd4:    uo_out = kappa_q[7:0];
                6'd5:    uo_out = inv_q[31:24];
                6'd6:    uo_out = inv_q[23:16];
                6'd7:    uo_out = inv_q[15:8];
                6'd8:    uo_out = inv_q[7:0];
                default: uo_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_eig_stream_engine.sv
// Scoreboard bench for eig_stream_engine: stimulus pushes expected frames,
// a monitor pops and compares each streamed frame and its arrival cycle.
`timescale 1ns/1ps
module tb_eig_stream_engine;

`ifdef EIG_INV_KAPPA_EN
    localparam int NB    = 9;
    localparam int L_HDR = 131;
`else
    localparam int NB    = 5;
    localparam int L_HDR = 83;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out, uio_oe, uo_out;

    eig_stream_engine dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .uo_out  (uo_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0][7:0] b;
        int              hdr_cyc;
        int              abort_at;
    } frame_t;

    frame_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic frame_t mk(input logic [2:0] rg, input logic [31:0] k,
                                  input logic [31:0] iv, input int hc, input int ab);
        frame_t f;
        logic [31:0] ive;
`ifdef EIG_INV_KAPPA_EN
        ive = iv;
`else
        ive = 32'h0;
`endif
        f.b = {ive[7:0], ive[15:8], ive[23:16], ive[31:24],
               k[7:0], k[15:8], k[23:16], k[31:24], {5'b10100, rg}};
        f.hdr_cyc  = hc;
        f.abort_at = ab;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask

    task automatic load_byte(input logic [2:0] a, input logic [7:0] d);
        tick();
        ui_in  = {2'b10, 3'b000, a};
        uio_in = d;
        tick();
        ui_in  = 8'h00;
    endtask

    task automatic load_word(input logic [2:0] base, input logic [31:0] w);
        for (int i = 0; i < 4; i++) load_byte(base + 3'(i), w[8*i +: 8]);
    endtask

    task automatic go(input logic [2:0] rg, input logic [31:0] k, input logic [31:0] iv,
                      input int extra, input int ab, output int g);
        tick();
        g = cyc + 1;
        exp_q.push_back(mk(rg, k, iv, g + L_HDR + extra, ab));
        ui_in[6] = 1'b1;
        tick();
        ui_in[6] = 1'b0;
    endtask

    // Monitor: a nonzero byte out of idle starts a frame; compare it against the queue head.
    initial begin : monitor
        frame_t f;
        forever begin
            @(negedge clk);
            if (rst_n && uo_out != 8'h00) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_stream: got byte %0h, required no output", uo_out);
                end else begin
                    f = exp_q.pop_front();
                    check("hdr_byte", {24'h0, uo_out}, {24'h0, f.b[0]});
                    check("hdr_cycle", 32'(cyc), 32'(f.hdr_cyc));
                    for (int i = 1; i < NB; i++) begin
                        @(negedge clk);
                        if (i == f.abort_at) begin
                            check("abort_uo_out", {24'h0, uo_out}, 32'h0);
                            check("abort_uio_oe", {24'h0, uio_oe}, 32'h0);
                            break;
                        end
                        check($sformatf("byte%0d", i), {24'h0, uo_out}, {24'h0, f.b[i]});
                    end
                    if (f.abort_at < 0) begin
                        @(negedge clk);
                        check("tail_zero", {24'h0, uo_out}, 32'h0);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int g;
        // Reset state
        repeat (3) tick();
        check("rst_uo_out", {24'h0, uo_out}, 32'h0);
        check("rst_uio_out", {24'h0, uio_out}, 32'h0);
        check("rst_uio_oe", {24'h0, uio_oe}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Real distinct: a1=-3, a0=2 -> kappa 2.0, inv 0.5
        load_word(3'd4, 32'hFFFD_0000);
        load_word(3'd0, 32'h0002_0000);
        go(3'd1, 32'h0002_0000, 32'h0000_8000, 0, -1, g);
        wait_cyc(g + L_HDR + NB + 3);

        // Load and go together: core sees a1=-3; A1 byte 2 becomes FB (a1=-5)
        tick();
        g = cyc + 1;
        exp_q.push_back(mk(3'd1, 32'h0002_0000, 32'h0000_8000, g + L_HDR, -1));
        ui_in  = 8'b1100_0110;
        uio_in = 8'hFB;
        tick();
        ui_in  = 8'h00;
        wait_cyc(g + L_HDR + NB + 3);

        // Real distinct: a1=-5 (from the combined load), a0=4 -> kappa 4.0, inv 0.25
        load_word(3'd0, 32'h0004_0000);
        go(3'd1, 32'h0004_0000, 32'h0000_4000, 0, -1, g);
        wait_cyc(g + L_HDR + NB + 3);

        // Repeated: a1=-2, a0=1
        load_word(3'd4, 32'hFFFE_0000);
        load_word(3'd0, 32'h0001_0000);
        go(3'd2, 32'h0001_0000, 32'h0001_0000, 0, -1, g);
        wait_cyc(g + L_HDR + NB + 3);

        // Complex: a1=0, a0=1
        load_word(3'd4, 32'h0000_0000);
        go(3'd3, 32'h0001_0000, 32'h0001_0000, 0, -1, g);
        wait_cyc(g + L_HDR + NB + 3);

        // Byte order: addresses 0..7 = 00 00 02 00 00 00 FD FF -> a0=2, a1=-3
        load_byte(3'd0, 8'h00);
        load_byte(3'd1, 8'h00);
        load_byte(3'd2, 8'h02);
        load_byte(3'd3, 8'h00);
        load_byte(3'd4, 8'h00);
        load_byte(3'd5, 8'h00);
        load_byte(3'd6, 8'hFD);
        load_byte(3'd7, 8'hFF);
        go(3'd1, 32'h0002_0000, 32'h0000_8000, 0, -1, g);
        wait_cyc(g + L_HDR + NB + 3);

        // Go while streaming is ignored
        go(3'd1, 32'h0002_0000, 32'h0000_8000, 0, -1, g);
        wait_cyc(g + L_HDR + 2);
        ui_in[6] = 1'b1;
        tick();
        ui_in[6] = 1'b0;
        wait_cyc(g + L_HDR + NB + 3);

        // ena low for 10 cycles mid-SQRT delays the header by 10
        go(3'd1, 32'h0002_0000, 32'h0000_8000, 10, -1, g);
        wait_cyc(g + 10);
        ena = 1'b0;
        repeat (10) tick();
        ena = 1'b1;
        wait_cyc(g + L_HDR + 10 + NB + 3);

        // Reset mid-stream aborts; afterwards zero operands give the singular result
        go(3'd1, 32'h0002_0000, 32'h0000_8000, 0, 2, g);
        wait_cyc(g + L_HDR + 2);
        rst_n = 1'b0;
        #1;
        check("midrst_uo_out", {24'h0, uo_out}, 32'h0);
        check("midrst_uio_oe", {24'h0, uio_oe}, 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        go(3'd4, 32'h7FFF_FFFF, 32'h0000_0000, 0, -1, g);
        wait_cyc(g + L_HDR + NB + 3);

        repeat (5) tick();
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
